// File: rtl/pcie_egress_sched.sv
// pcie_egress_sched
//
// Purpose:
//   Egress scheduler that drains the two virtual-channel FIFOs (D0, D1)
//   onto one shared egress link. It uses burst-limited round-robin
//   arbitration and holds one registered output slot with valid/ready
//   backpressure.
//
// Optional feature macro: SCHED_STRICT_PRIO_EN
//   Defined   : D0 has strict priority. D1 is popped only when D0 is empty,
//               and the burst counter and last-served flag are not used.
//   Undefined : burst-limited round-robin, with at most BURST consecutive
//               grants to one channel while the other channel waits.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   D0_can_pop  in   D0 FIFO non-empty (data_out0 valid)
//   D1_can_pop  in   D1 FIFO non-empty (data_out1 valid)
//   data_out0   in   D0 FIFO head word (first-word-fall-through)
//   data_out1   in   D1 FIFO head word (first-word-fall-through)
//   link_ready  in   downstream accepts link_data this cycle
//   pop_D0      out  consume D0 head this cycle (combinational)
//   pop_D1      out  consume D1 head this cycle (combinational)
//   link_data   out  registered egress word
//   link_valid  out  link_data valid
//   link_src    out  source channel of link_data (0 = D0, 1 = D1)
//   busy        out  scheduler is not idle (registered)

module pcie_egress_sched #(
    parameter int BITNUMBER = 6,
    parameter int BURST     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 D0_can_pop,
    input  logic                 D1_can_pop,
    input  logic [BITNUMBER-1:0] data_out0,
    input  logic [BITNUMBER-1:0] data_out1,
    input  logic                 link_ready,
    output logic                 pop_D0,
    output logic                 pop_D1,
    output logic [BITNUMBER-1:0] link_data,
    output logic                 link_valid,
    output logic                 link_src,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE0 = 2'd1,
        ST_SERVE1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_L = 4'(BURST);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_nxt;
    logic                 r_last;
    logic                 w_last_nxt;
    logic [BITNUMBER-1:0] r_data;
    logic                 r_valid;
    logic                 r_src;
    logic                 r_busy;
    logic                 w_slot_free;
    logic                 w_pop0;
    logic                 w_pop1;

    // The slot can take a new word when it is empty or is being drained.
    assign w_slot_free = !r_valid || link_ready;

    // Gate the pops with reset so that no FIFO word is consumed while in reset.
    assign pop_D0 = w_pop0 && reset;
    assign pop_D1 = w_pop1 && reset;

    assign link_data  = r_data;
    assign link_valid = r_valid;
    assign link_src   = r_src;
    assign busy       = r_busy;

    // State register for the arbitration FSM, burst counter and last-served flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_last  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef SCHED_STRICT_PRIO_EN
    // Strict priority: D0 always wins; the state only tracks which channel was granted.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_pop0      = 1'b0;
        w_pop1      = 1'b0;
        if (w_slot_free) begin
            if (D0_can_pop) begin
                w_pop0      = 1'b1;
                w_state_nxt = ST_SERVE0;
            end else if (D1_can_pop) begin
                w_pop1      = 1'b1;
                w_state_nxt = ST_SERVE1;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end
`else
    // Burst-limited round-robin: next state, counter, last-served flag and pops.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_pop0      = 1'b0;
        w_pop1      = 1'b0;
        if (w_slot_free) begin
            case (r_state)
                ST_IDLE: begin
                    // On a tie, the channel that was not served last wins.
                    if (D0_can_pop && (!D1_can_pop || r_last)) begin
                        w_pop0      = 1'b1;
                        w_state_nxt = ST_SERVE0;
                        w_cnt_nxt   = 4'd1;
                    end else if (D1_can_pop) begin
                        w_pop1      = 1'b1;
                        w_state_nxt = ST_SERVE1;
                        w_cnt_nxt   = 4'd1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_SERVE0: begin
                    if ((r_cnt < BURST_L) && D0_can_pop) begin
                        w_pop0    = 1'b1;
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (D1_can_pop) begin
                        w_pop1      = 1'b1;
                        w_state_nxt = ST_SERVE1;
                        w_cnt_nxt   = 4'd1;
                    end else if (D0_can_pop) begin
                        // Burst exhausted but D1 is empty: restart the burst without a bubble.
                        w_pop0    = 1'b1;
                        w_cnt_nxt = 4'd1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_last_nxt  = 1'b0;
                    end
                end
                ST_SERVE1: begin
                    if ((r_cnt < BURST_L) && D1_can_pop) begin
                        w_pop1    = 1'b1;
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (D0_can_pop) begin
                        w_pop0      = 1'b1;
                        w_state_nxt = ST_SERVE0;
                        w_cnt_nxt   = 4'd1;
                    end else if (D1_can_pop) begin
                        w_pop1    = 1'b1;
                        w_cnt_nxt = 4'd1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_last_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end
`endif

    // Output slot: capture the popped word, or empty the slot once it has been drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data  <= {BITNUMBER{1'b0}};
            r_valid <= 1'b0;
            r_src   <= 1'b0;
        end else if (w_slot_free) begin
            if (w_pop0 || w_pop1) begin
                r_data  <= w_pop1 ? data_out1 : data_out0;
                r_src   <= w_pop1;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end else begin
            r_valid <= r_valid;
        end
    end

endmodule

// File: tb/tb_pcie_egress_sched.sv
module tb_pcie_egress_sched;

    logic       clk;
    logic       reset;
    logic       d0_can;
    logic       d1_can;
    logic [5:0] d0_dat;
    logic [5:0] d1_dat;
    logic       link_ready;
    logic       pop_D0;
    logic       pop_D1;
    logic [5:0] link_data;
    logic       link_valid;
    logic       link_src;
    logic       busy;

    pcie_egress_sched #(.BITNUMBER(6), .BURST(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .D0_can_pop (d0_can),
        .D1_can_pop (d1_can),
        .data_out0  (d0_dat),
        .data_out1  (d1_dat),
        .link_ready (link_ready),
        .pop_D0     (pop_D0),
        .pop_D1     (pop_D1),
        .link_data  (link_data),
        .link_valid (link_valid),
        .link_src   (link_src),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       src;
        logic [5:0] data;
    } exp_t;

    typedef struct {
        logic c0;
        logic c1;
        logic rdy;
        logic e_pop0;
        logic e_pop1;
        logic e_valid;
        logic e_busy;
    } vec_t;

    exp_t       exp_q[$];
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    int         n_pass  = 0;
    int         n_total = 0;
    logic       s_pop0;
    logic       s_pop1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic push_exp(input logic src, input logic [5:0] data);
        exp_t e;
        e.src  = src;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // One cycle driven from the FIFO models; compares every accepted word.
    task automatic step();
        exp_t e;
        d0_can = (q0.size() > 0);
        d1_can = (q1.size() > 0);
        d0_dat = (q0.size() > 0) ? q0[0] : 6'd0;
        d1_dat = (q1.size() > 0) ? q1[0] : 6'd0;
        #1;
        s_pop0 = pop_D0;
        s_pop1 = pop_D1;
        check("pop_onehot", {31'd0, s_pop0 & s_pop1}, 32'd0);
        check("pop_no_data", {31'd0, (s_pop0 & !d0_can) | (s_pop1 & !d1_can)}, 32'd0);
        if (link_valid && link_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_src", {31'd0, link_src}, {31'd0, e.src});
                check("sb_data", {26'd0, link_data}, {26'd0, e.data});
            end
        end
        @(posedge clk);
        if (s_pop0) void'(q0.pop_front());
        if (s_pop1) void'(q1.pop_front());
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        q0.delete();
        q1.delete();
    endtask

    task automatic drain(input string name, input int req_steps);
        int steps;
        steps = 0;
        while (exp_q.size() > 0 && steps < 200) begin
            step();
            steps++;
        end
        check({name, "_cycles"}, steps, req_steps);
        check({name, "_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        vec_t tbl[12];
        int   p0;
        int   p1;
        reset      = 1'b0;
        d0_can     = 1'b1;
        d1_can     = 1'b1;
        d0_dat     = 6'h11;
        d1_dat     = 6'h22;
        link_ready = 1'b1;
        s_pop0     = 1'b0;
        s_pop1     = 1'b0;

        // Reset hold
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_pop0", {31'd0, pop_D0}, 32'd0);
            check("rst_pop1", {31'd0, pop_D1}, 32'd0);
            check("rst_valid", {31'd0, link_valid}, 32'd0);
            check("rst_data", {26'd0, link_data}, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

`ifndef SCHED_STRICT_PRIO_EN
        // Table: {c0, c1, ready, pop0, pop1, valid, busy}, applied from a fresh reset
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 12; i++) begin
            d0_can     = tbl[i].c0;
            d1_can     = tbl[i].c1;
            link_ready = tbl[i].rdy;
            #1;
            check($sformatf("tbl%0d_pop0", i), {31'd0, pop_D0}, {31'd0, tbl[i].e_pop0});
            check($sformatf("tbl%0d_pop1", i), {31'd0, pop_D1}, {31'd0, tbl[i].e_pop1});
            check($sformatf("tbl%0d_valid", i), {31'd0, link_valid}, {31'd0, tbl[i].e_valid});
            check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
            @(posedge clk);
            #1;
        end
        link_ready = 1'b1;

        // Fair drain: both channels hold 12 words
        do_reset();
        for (int i = 0; i < 12; i++) begin
            q0.push_back(6'(i));
            q1.push_back(6'(32 + i));
        end
        for (int b = 0; b < 6; b++)
            for (int k = 0; k < 4; k++)
                push_exp(1'(b % 2), (b % 2 == 1) ? 6'(32 + (b / 2) * 4 + k) : 6'((b / 2) * 4 + k));
        drain("fair", 25);

        // Single channel: D1 only, no bubble at the burst wrap
        do_reset();
        for (int i = 0; i < 10; i++) begin
            q1.push_back(6'(16 + i));
            push_exp(1'b1, 6'(16 + i));
        end
        drain("single", 11);
        check("single_busy", {31'd0, busy}, 32'd0);
        q0.push_back(6'h01);
        q1.push_back(6'h3F);
        step();
        check("single_last_tie", {30'd0, s_pop1, s_pop0}, 32'd1);

        // Backpressure
        do_reset();
        q0.push_back(6'h2A);
        q0.push_back(6'h15);
        push_exp(1'b0, 6'h2A);
        push_exp(1'b0, 6'h15);
        step();
        link_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_nopop", {30'd0, s_pop1, s_pop0}, 32'd0);
            check("bp_data", {26'd0, link_data}, 32'h2A);
            check("bp_valid", {31'd0, link_valid}, 32'd1);
        end
        link_ready = 1'b1;
        step();
        check("bp_same_cycle_pop", {30'd0, s_pop1, s_pop0}, 32'd1);
        check("bp_next_data", {26'd0, link_data}, 32'h15);
        drain("bp", 1);

        // Mid-burst reset at cnt = 2 in SERVE1
        do_reset();
        for (int i = 0; i < 5; i++) q1.push_back(6'(48 + i));
        push_exp(1'b1, 6'd48);
        step();
        step();
        check("mr_src_before", {31'd0, link_src}, 32'd1);
        q0.push_back(6'h05);
        q0.push_back(6'h06);
        d0_can = 1'b1;
        d1_can = 1'b1;
        reset  = 1'b0;
        #1;
        check("mr_pop", {30'd0, pop_D1, pop_D0}, 32'd0);
        check("mr_valid", {31'd0, link_valid}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        push_exp(1'b0, 6'h05);
        step();
        check("mr_first_grant", {30'd0, s_pop1, s_pop0}, 32'd1);
        step();
        check("mr_left", exp_q.size(), 32'd0);
`else
        // Strict priority: D0 wins every tie, D1 follows immediately once D0 empties
        do_reset();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(6'(i));
            push_exp(1'b0, 6'(i));
        end
        for (int i = 0; i < 3; i++) begin
            q1.push_back(6'(32 + i));
            push_exp(1'b1, 6'(32 + i));
        end
        p0 = 0;
        p1 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            p0 += int'(s_pop0);
            p1 += int'(s_pop1);
        end
        check("sp_pop0", p0, 32'd8);
        check("sp_pop1", p1, 32'd0);
        step();
        check("sp_d1_next", {30'd0, s_pop1, s_pop0}, 32'd2);
        drain("sp", 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pcie_egress_sched.md
# pcie_egress_sched

Egress scheduler for the PCIe transaction datapath. Drains the two post-demux virtual-channel FIFOs (D0 and D1) onto a single shared egress link, issuing `pop_D0`/`pop_D1` with burst-limited round-robin arbitration. It holds one registered output slot with valid/ready backpressure. It sits between `pcie_trans` (FIFO outputs) and the downstream link/serializer.

## Interface
Parameters:
- `BITNUMBER`, 6, data word width (matches `pcie_trans`).
- `BURST`, 4, max consecutive grants to one channel while the other channel waits; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `D0_can_pop`  in  1  D0 FIFO non-empty; `data_out0` valid.
- `D1_can_pop`  in  1  D1 FIFO non-empty; `data_out1` valid.
- `data_out0`  in  BITNUMBER  D0 FIFO head word (first-word-fall-through).
- `data_out1`  in  BITNUMBER  D1 FIFO head word (first-word-fall-through).
- `link_ready`  in  1  downstream accepts `link_data` this cycle.
- `pop_D0`  out  1  consume D0 head this cycle (combinational).
- `pop_D1`  out  1  consume D1 head this cycle (combinational).
- `link_data`  out  BITNUMBER  registered egress word.
- `link_valid`  out  1  `link_data` valid.
- `link_src`  out  1  source channel of `link_data` (0 = D0, 1 = D1).
- `busy`  out  1  state is not IDLE.

## Operation
- Slot free condition: `slot_free = !link_valid || link_ready`. Pops are issued only when `slot_free` is 1.
- On a pop, the selected head word, the channel ID, and `link_valid = 1` are registered at the same clock edge.
- If `slot_free` is 1 and no pop occurs, `link_valid` clears.
- At most one pop per cycle; `pop_D0 & pop_D1` is never 1.
- A pop is never issued while its channel's `can_pop` is 0.
- Registers:
  - state: IDLE, SERVE0, SERVE1.
  - `cnt`: grants in the current burst, 4 bits.
  - `last`: last channel served.
- Transitions are evaluated only when `slot_free` is 1; otherwise state, `cnt` and `last` hold.
- IDLE:
  - If exactly one channel is ready, grant it.
  - If both are ready, grant `!last`.
  - After a grant, enter SERVEx with `cnt = 1`. With no ready channel, stay in IDLE.
- SERVEx (x = current channel, y = other):
  - `cnt < BURST` and x ready: pop x, `cnt++`.
  - Else, y ready: pop y, go to SERVEy, `cnt = 1`.
  - Else, x ready (burst exhausted, y empty): pop x, `cnt = 1` (burst restarts, no bubble).
  - Else: go to IDLE, `last = x`.
- Reset values: `link_data = 0`, `link_valid = 0`, `link_src = 0`, `busy = 0`, state IDLE, `cnt = 0`, `last = 1` (so D0 wins the first tie).
- While `reset` is low, `pop_D0` and `pop_D1` are forced to 0.
- Reset asserted mid-burst clears everything immediately. Words already popped but not yet accepted downstream are discarded.

## Timing
- Pop in cycle N drives `link_valid = 1` and `link_data` in cycle N+1: one-cycle latency.
- Full throughput of one word/cycle while `link_ready` stays 1 and any channel is non-empty.
- With `link_ready` low and `link_valid` high, `link_data`/`link_src` stay stable and no pops are issued.
- The first pop is allowed in the first cycle after `reset` deasserts.

## Configuration
- `SCHED_STRICT_PRIO_EN`:
  - Defined: D0 has strict priority. D1 is popped only when `D0_can_pop` is 0. `BURST`, `cnt` and `last` are ignored.
  - Undefined: burst-limited round-robin as described above.

## Test plan
- Reset hold: `reset = 0`, both `can_pop = 1`, `link_ready = 1` -> `pop_D0 = pop_D1 = 0`, `link_valid = 0`, `link_data = 0` throughout.
- Fair drain, BURST = 4: both channels hold 12 words, `link_ready = 1`.
  - Expected `link_src`: 0×4, 1×4, 0×4, 1×4, 0×4, 1×4.
  - No idle cycles; data order matches FIFO order.
- Single channel: only D1 holds 10 words -> 10 consecutive `pop_D1`, no bubble at the `cnt` wrap. Then IDLE, `busy = 0`, `last = 1`.
- Backpressure: `link_ready = 0` for 3 cycles with `link_valid = 1`, data 0x2A -> `link_data = 0x2A` stable, no pops. The word is accepted when `link_ready` returns, and the next pop occurs in that same cycle.
- Mid-burst reset: assert `reset` low at `cnt = 2` in SERVE1 -> same-cycle pops 0 and `link_valid = 0`. After release with both channels ready, the first grant is D0.
- With `SCHED_STRICT_PRIO_EN`: both channels ready for 8 cycles -> 8 `pop_D0` and 0 `pop_D1`. Once D0 empties, D1 is popped in the next cycle.
